// File: rtl/run_length_detector_if.sv
// Bundle between the serial front end and the run detector.
// Inputs are sample controls; outputs are detection status.
interface run_length_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int RW = $clog2(RUN_LEN + 1);

  logic             en;
  logic             w;
  logic [1:0]       mode;
  logic             z;
  logic             z_pol;
  logic [RW-1:0]    run_cnt;
  logic [CNT_W-1:0] det_cnt;
  logic [RW+1:0]    y;

  modport master (
    output en, w, mode,
    input  z, z_pol, run_cnt, det_cnt, y
  );

  modport slave (
    input  en, w, mode,
    output z, z_pol, run_cnt, det_cnt, y
  );
endinterface

// File: rtl/run_length_detector.sv
// Flags RUN_LEN identical consecutive samples of a serial bit.
// Level or one-clock pulse indication, with a wrapping event count.
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  aclr,
  run_length_detector_if.slave bus
);
  localparam int RW = $clog2(RUN_LEN + 1);

  localparam logic [RW-1:0]    FULL    = RW'(RUN_LEN);
  localparam logic [RW-1:0]    NEAR    = RW'(RUN_LEN - 1);
  localparam logic [RW-1:0]    ONE     = RW'(1);
  localparam logic [CNT_W-1:0] DET_ONE = CNT_W'(1);

  logic             started_q, started_d;
  logic             last_q, last_d;
  logic             hit_q, hit_d;
  logic [RW-1:0]    run_q, run_d;
  logic [CNT_W-1:0] det_q, det_d;
  logic             full;

  // State register; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (aclr) begin
      started_q <= 1'b0;
      last_q    <= 1'b0;
      hit_q     <= 1'b0;
      run_q     <= '0;
      det_q     <= '0;
    end else begin
      started_q <= started_d;
      last_q    <= last_d;
      hit_q     <= hit_d;
      run_q     <= run_d;
      det_q     <= det_d;
    end
  end

  // Next state: restart on a new polarity, otherwise extend and saturate.
  // A detection is only the step from RUN_LEN-1 to RUN_LEN.
  always_comb begin
    started_d = started_q;
    last_d    = last_q;
    run_d     = run_q;
    det_d     = det_q;
    hit_d     = 1'b0;
    if (bus.en) begin
      if (!started_q || (bus.w != last_q)) begin
        started_d = 1'b1;
        last_d    = bus.w;
        run_d     = ONE;
      end else if (run_q != FULL) begin
        run_d = run_q + ONE;
      end
      hit_d = (run_q == NEAR) && (run_d == FULL);
      if (hit_d) begin
        det_d = det_q + DET_ONE;
      end
    end
  end

  // Outputs depend only on registers and mode, never on w.
  always_comb begin
    full = (run_q == FULL);
    bus.z = 1'b0;
    unique case (bus.mode)
      2'b00:   bus.z = full;
      2'b01:   bus.z = full & ~last_q;
      2'b10:   bus.z = full & last_q;
      2'b11:   bus.z = hit_q;
      default: bus.z = 1'b0;
    endcase
  end

  assign bus.z_pol   = last_q & started_q;
  assign bus.run_cnt = run_q;
  assign bus.det_cnt = det_q;
  assign bus.y       = {started_q, last_q, run_q};
endmodule

// File: tb/tb_run_length_detector.sv
// Directed and random checks of run_length_detector.
// Two builds share stimulus: RUN_LEN=4/CNT_W=8 and RUN_LEN=2/CNT_W=2.
module tb_run_length_detector;
  logic clk = 1'b0;
  logic aclr;

  always #5 clk = ~clk;

  run_length_detector_if #(.RUN_LEN(4), .CNT_W(8)) b1 ();
  run_length_detector_if #(.RUN_LEN(2), .CNT_W(2)) b2 ();

  run_length_detector #(.RUN_LEN(4), .CNT_W(8)) u_dut1 (
    .clk  (clk),
    .aclr (aclr),
    .bus  (b1.slave)
  );

  run_length_detector #(.RUN_LEN(2), .CNT_W(2)) u_dut2 (
    .clk  (clk),
    .aclr (aclr),
    .bus  (b2.slave)
  );

  int total = 0;
  int passed = 0;

  // Reference: history of accepted samples since reset.
  bit hist[$];
  int det1 = 0;
  int det2 = 0;
  bit hit1 = 0;
  bit hit2 = 0;
  logic [1:0] cur_mode = 2'b00;
  bit prev_w = 0;

  function automatic int trail();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int run_of(int L);
    int t;
    t = trail();
    return (t > L) ? L : t;
  endfunction

  function automatic bit last_bit();
    return (hist.size() > 0) ? hist[hist.size() - 1] : 1'b0;
  endfunction

  function automatic bit exp_z(int L, bit hit);
    bit full;
    full = (hist.size() > 0) && (run_of(L) == L);
    case (cur_mode)
      2'b00:   return full;
      2'b01:   return full & ~last_bit();
      2'b10:   return full & last_bit();
      default: return hit;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int r1, r2, s, l;
    r1 = run_of(4);
    r2 = run_of(2);
    s  = (hist.size() > 0) ? 1 : 0;
    l  = last_bit();
    chk("z1", 32'(b1.z), 32'(exp_z(4, hit1)));
    chk("zpol1", 32'(b1.z_pol), 32'(l));
    chk("run1", 32'(b1.run_cnt), 32'(r1));
    chk("det1", 32'(b1.det_cnt), 32'(det1 % 256));
    chk("y1", 32'(b1.y), 32'(s * 16 + l * 8 + r1));
    chk("z2", 32'(b2.z), 32'(exp_z(2, hit2)));
    chk("zpol2", 32'(b2.z_pol), 32'(l));
    chk("run2", 32'(b2.run_cnt), 32'(r2));
    chk("det2", 32'(b2.det_cnt), 32'(det2 % 4));
    chk("y2", 32'(b2.y), 32'(s * 8 + l * 4 + r2));
  endtask

  task automatic step(bit r, bit e, bit wv, logic [1:0] m);
    int t;
    @(negedge clk);
    aclr = r;
    b1.en = e; b2.en = e;
    b1.w = wv; b2.w = wv;
    b1.mode = m; b2.mode = m;
    cur_mode = m;
    @(posedge clk);
    if (r) begin
      hist.delete();
      det1 = 0; det2 = 0;
      hit1 = 0; hit2 = 0;
    end else if (e) begin
      hist.push_back(wv);
      if (hist.size() > 64) void'(hist.pop_front());
      t = trail();
      hit1 = (t == 4);
      hit2 = (t == 2);
      det1 += int'(hit1);
      det2 += int'(hit2);
    end else begin
      hit1 = 0;
      hit2 = 0;
    end
    #1;
    check_all();
  endtask

  task automatic set_mode(logic [1:0] m);
    @(negedge clk);
    b1.mode = m; b2.mode = m;
    cur_mode = m;
    #1;
    check_all();
  endtask

  task automatic rst();
    step(1, 1, 0, cur_mode);
  endtask

  initial begin
    aclr = 1'b1;
    b1.en = 0; b2.en = 0;
    b1.w = 0; b2.w = 0;
    b1.mode = 0; b2.mode = 0;

    // Reset state.
    rst();
    rst();
    chk("rst_y", 32'(b1.y), 32'd0);
    chk("rst_z", 32'(b1.z), 32'd0);

    // Five zeros then a one, level mode.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b00);
    chk("t1_z5", 32'(b1.z), 32'd1);
    step(0, 1, 1, 2'b00);
    chk("t1_det", 32'(b1.det_cnt), 32'd1);
    chk("t1_z", 32'(b1.z), 32'd0);

    // Pulse mode on a run of six ones.
    rst();
    for (int i = 0; i < 6; i++) step(0, 1, 1, 2'b11);
    chk("t2_det", 32'(b1.det_cnt), 32'd1);
    chk("t2_run", 32'(b1.run_cnt), 32'd4);

    // Zeros-only mode, then live mode switch.
    rst();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b01);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b01);
    chk("t3_z", 32'(b1.z), 32'd1);
    set_mode(2'b10);
    chk("t3_sw", 32'(b1.z), 32'd0);
    set_mode(2'b00);

    // Enable gating inside a run.
    rst();
    step(0, 1, 0, 2'b00);
    step(0, 0, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    step(0, 0, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    chk("t4_run3", 32'(b1.run_cnt), 32'd3);
    step(0, 1, 0, 2'b00);
    chk("t4_z", 32'(b1.z), 32'd1);

    // Reset mid-run.
    rst();
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b00);
    rst();
    chk("t5_y", 32'(b1.y), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b00);
    chk("t5_det", 32'(b1.det_cnt), 32'd1);

    // Alternating runs; small counter wraps.
    rst();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b00);
    end
    chk("t6_det1", 32'(b1.det_cnt), 32'd10);
    chk("t6_det2", 32'(b2.det_cnt), 32'd2);

    // Random runs with sparse resets and mode changes.
    for (int n = 0; n < 2000; n++) begin
      bit r, e, wv;
      logic [1:0] m;
      r  = ($urandom_range(0, 63) == 0);
      e  = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 3) == 0) ? ~prev_w : prev_w;
      prev_w = wv;
      m  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3))
                                        : cur_mode;
      step(r, e, wv, m);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
Parametrised successor to the fixed four-in-a-row serial pattern FSM. It watches a serial bit stream `w` and flags a run of RUN_LEN identical bits, either zeros or ones.
- Run length and counter widths are parameters.
- Adds a sample enable, a polarity/mode select, level or single-pulse indication, a detection counter, and exposure of the current run state.
- Sits after a serial input synchroniser; feeds status and interrupt logic.

Parameters:
- RUN_LEN, 4, number of consecutive identical bits that constitutes a detection; legal range 2..255.
- CNT_W, 8, width of the detection event counter `det_cnt`.
- RW (derived, localparam), $clog2(RUN_LEN+1), width of the run-length counter.

Ports:
- clk  input  1  rising-edge clock.
- aclr  input  1  reset; synchronous, active-high, sampled on rising clk (name kept per codebase convention).
- en  input  1  sample enable; `w` is consumed only on clocks with en=1.
- w  input  1  serial data bit.
- mode  input  2  00 both polarities level; 01 zeros only level; 10 ones only level; 11 both polarities single-clock pulse.
- z  output  1  detection flag (see Behaviour).
- z_pol  output  1  polarity of current run: 0 = zeros, 1 = ones; 0 when no sample taken.
- run_cnt  output  RW  current run length, saturating at RUN_LEN.
- det_cnt  output  CNT_W  number of detections since reset; wraps modulo 2^CNT_W.
- y  output  RW+2  state vector {started, last, run_cnt}, for debug.

Behaviour:
Registers are `started`, `last`, `run_cnt`, `hit` and `det_cnt`. All update on rising clk.

Reset (aclr=1 at a clk edge): started=0, last=0, run_cnt=0, hit=0, det_cnt=0. Therefore z=0, z_pol=0 and y=0 in the cycle after. Reset has priority over en. Reset mid-run discards the run; counting restarts at the next enabled sample.

Enabled sample (en=1, aclr=0):
- If started=0, or w!=last: last<=w, run_cnt<=1, started<=1.
- Else (w==last): run_cnt<=min(run_cnt+1, RUN_LEN). It holds at RUN_LEN while the run continues.
- hit<=1 iff the new run_cnt==RUN_LEN and the old run_cnt==RUN_LEN-1 (first arrival only); otherwise hit<=0.
- det_cnt<=det_cnt+1 on the same condition as hit, independent of mode. It wraps from 2^CNT_W-1 to 0.

Disabled clock (en=0, aclr=0):
- started, last, run_cnt and det_cnt hold.
- hit<=0, so a pulse is always exactly one clock wide.

Outputs are combinational from registers and `mode` (Moore-style, no path from `w`). Let full = (run_cnt==RUN_LEN).
- mode 00: z = full.
- mode 01: z = full & ~last.
- mode 10: z = full & last.
- mode 11: z = hit.
- z_pol = last & started.

Mode changes take effect on z immediately, with no state change.

Latency: a detection is visible on z the clock after the RUN_LEN-th identical enabled sample.

Polarity switch: a run of RUN_LEN zeros immediately followed by ones clears z on the first one (run_cnt=1). A later run of RUN_LEN ones is a new detection.

A continuing run beyond RUN_LEN:
- keeps z high in level modes;
- produces no additional pulse and no additional det_cnt increment.

Equivalence check: with RUN_LEN=4 and mode=00, z must match the legacy four-in-a-row detector sample-for-sample (en tied high).

Test Plan:
1. Reset, mode=00, en=1, w=0,0,0,0,0,1 -> run_cnt 1,2,3,4,4,1; z high on the 4th and 5th post-sample cycles only; det_cnt=1.
2. mode=11, w=1 x6 -> z pulses exactly one clock after the 4th one; z_pol=1; det_cnt=1; run_cnt stays 4.
3. mode=01 with 4 ones then 4 zeros -> z low during the ones, high after the 4th zero; switching mode to 10 while high -> z drops the same cycle.
4. en gating: w=0 with en pattern 1,0,1,0,1,1 (en low for 2 clocks inside the run) -> run_cnt reaches 4 only after the 4th enabled sample; z timing shifts accordingly.
5. aclr asserted after 3 ones, then w=1 x4 -> y=0 after reset; detection only after 4 fresh ones; det_cnt=1.
6. CNT_W=2, alternating runs 0000 1111 repeated 5 times -> det_cnt sequence 1,2,3,0,1,... wraps; RUN_LEN=2 build: w=1,1 -> z after 2nd sample.
